divider_seq: RTL and testbench
==============================

// Module: divider_seq
// PURPOSE
//  Sequential radix-2 restoring integer divider: the inverse of the array multiplier.
//  Computes Q = A / B and R = A % B, one quotient bit per clock, under a start/done handshake.
//  Sits beside the multiplier in the arithmetic datapath and shares its operand width convention.
// PARAMETERS
//  bw    16    operand width; dividend, divisor, quotient and remainder are all bw bits
// PORTS
//  CLK          in   1       rising-edge clock
//  RESETn       in   1       asynchronous active-low reset
//  start        in   1       request; sampled only when state is IDLE or DONE
//  A            in   [bw:1]  dividend, captured on the accepting edge
//  B            in   [bw:1]  divisor, captured on the accepting edge
//  busy         out  1       high while in RUN
//  done         out  1       one-cycle pulse: Q/R/div_by_zero valid
//  Q            out  [bw:1]  quotient, registered, held until next accepted start
//  R            out  [bw:1]  remainder, registered, held until next accepted start
//  div_by_zero  out  1       registered flag for the current result, held with Q/R
// BEHAVIOUR
//  - Reset (RESETn=0, async): state=IDLE; busy=0, done=0, Q=0, R=0, div_by_zero=0; counter=0.
//  - States: IDLE -> RUN on start; RUN -> DONE after bw iterations; DONE -> IDLE (no start)
//    or DONE -> RUN (start high in DONE: back-to-back, no idle bubble).
//  - Accept edge: latch A into dividend shift reg, B into divisor reg, clear partial
//    remainder (bw+1 bits), counter=0, busy=1.
//  - Each RUN edge: rem' = {rem[bw-1:0], dividend MSB}; trial = rem' - {1'b0,divisor};
//    trial sign 0 -> rem=trial, shift quotient bit 1; else keep rem', shift 0. counter++.
//  - Latency: done=1 in the cycle after the bw-th RUN edge, i.e. bw edges after the accept
//    edge (16 for default). Q, R, div_by_zero update on that same edge; busy drops to 0 with it.
//  - done is high exactly one cycle; Q/R stay stable in IDLE until the next accepted start,
//    after which they hold old values until the new done (no intermediate values visible).
//  - start while busy=1 is ignored (no queueing, no restart, operands not resampled).
//  - Divide by zero: B==0 at accept edge -> skip RUN; next edge enters DONE with done=1,
//    Q = all ones, R = A, div_by_zero=1. Latency 1 edge.
//  - div_by_zero clears to 0 on every non-zero-divisor result.
//  - Reset asserted mid-RUN aborts the operation; no done pulse; all outputs to reset values.
//  - A < B: Q=0, R=A after full bw-cycle latency (no early exit).
// CONFIGURATION
//  SIGNED_DIV_EN defined: A, B are two's complement. Magnitudes are divided by the same
//    unsigned core; Q negated if signs differ, R takes sign of A (truncation toward zero).
//    Sign fix applied when Q/R are written; latency unchanged.
//    Overflow A = -2^(bw-1), B = -1: Q = -2^(bw-1) (0x8000), R = 0, div_by_zero=0.
//    B==0: Q = all ones, R = A, div_by_zero=1 (same as unsigned).
//  SIGNED_DIV_EN undefined: all operands unsigned; no sign logic synthesised.
// TESTING
//  1. A=100, B=7, start 1 cycle -> done exactly 16 edges later; Q=14, R=2, div_by_zero=0.
//  2. A=0xFFFF, B=1 -> Q=0xFFFF, R=0; then A=5, B=0xFFFF -> Q=0, R=5.
//  3. A=1234, B=0 -> done 1 edge after accept; Q=0xFFFF, R=1234, div_by_zero=1;
//     next op A=9, B=3 -> Q=3, R=0, div_by_zero=0.
//  4. start A=100,B=7, re-pulse start with A=50,B=5 at edge 5 of RUN -> ignored; Q=14, R=2;
//     start held high in DONE with A=50,B=5 -> accepted, next done Q=10, R=0.
//  5. RESETn low at edge 8 of RUN -> outputs 0 immediately, no done; restart A=9,B=2 ->
//     Q=4, R=1 after 16 edges.
//  6. SIGNED_DIV_EN: A=-7 (0xFFF9), B=2 -> Q=0xFFFD (-3), R=0xFFFF (-1);
//     A=0x8000, B=0xFFFF -> Q=0x8000, R=0; random 1000-vector compare vs $signed model.

Source files
------------

// File: rtl/divider_seq.sv
// ----------------------------------------------------------------------------
// divider_seq
//   Sequential radix-2 restoring integer divider. Produces Q = A / B and
//   R = A % B, one quotient bit per clock, behind a start/done handshake.
//   Operand width follows the array multiplier: all operands are bw bits,
//   numbered [bw:1] on the ports.
//
//   Optional feature macro: SIGNED_DIV_EN
//     defined   - A and B are two's complement; magnitudes go through the
//                 unsigned core and the result signs are fixed on write-back
//                 (truncation toward zero, R takes the sign of A).
//     undefined - purely unsigned; no sign logic is built.
//
//   Timing: the accept edge loads the operands, then bw RUN edges each
//   resolve one quotient bit. The last RUN edge writes Q/R and raises done,
//   so done is visible bw edges after the accept edge. A zero divisor skips
//   the iterations and finishes on the first RUN edge.
// ----------------------------------------------------------------------------
module divider_seq #(
    parameter int bw = 16
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    input  logic [bw:1]   A,
    input  logic [bw:1]   B,
    output logic          busy,
    output logic          done,
    output logic [bw:1]   Q,
    output logic [bw:1]   R,
    output logic          div_by_zero
);

    // Counter only needs to reach bw-1; one spare bit keeps bw a power of two safe.
    localparam int            CW       = $clog2(bw + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(bw - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [bw-1:0]   r_dividend;   // dividend shifts out MSB-first; quotient bits shift in at LSB
    logic [bw-1:0]   r_divisor;
    logic [bw-1:0]   r_rem;        // partial remainder; always < divisor between iterations
    logic [CW-1:0]   r_cnt;
    logic            r_zero;       // divisor was zero at accept: skip the iterations
    logic            r_busy;
    logic            r_done;
    logic [bw-1:0]   r_q;
    logic [bw-1:0]   r_r;
    logic            r_dz;
`ifdef SIGNED_DIV_EN
    logic            r_neg_q;      // operand signs differ: negate quotient
    logic            r_neg_r;      // dividend negative: negate remainder
`endif

    // ------------------------------------------------------------------
    // Operand conditioning at the accept edge
    // ------------------------------------------------------------------
    logic            w_b_zero;
    logic [bw-1:0]   w_a_load;
    logic [bw-1:0]   w_b_load;

    assign w_b_zero = (B == '0);

`ifdef SIGNED_DIV_EN
    logic [bw-1:0]   w_a_mag;
    logic [bw-1:0]   w_b_mag;

    // -(-2^(bw-1)) wraps to itself, which is the correct unsigned magnitude.
    assign w_a_mag  = A[bw] ? -A : A;
    assign w_b_mag  = B[bw] ? -B : B;
    // A zero divisor returns A untouched as the remainder, so keep it raw.
    assign w_a_load = w_b_zero ? A : w_a_mag;
    assign w_b_load = w_b_mag;
`else
    assign w_a_load = A;
    assign w_b_load = B;
`endif

    // ------------------------------------------------------------------
    // One restoring iteration
    // ------------------------------------------------------------------
    logic [bw:0]     w_rem_shift;
    logic [bw:0]     w_trial;
    logic            w_q_bit;
    logic [bw-1:0]   w_rem_next;
    logic [bw-1:0]   w_quot_next;

    // Bring the next dividend bit into the partial remainder.
    assign w_rem_shift = {r_rem, r_dividend[bw-1]};
    // Trial subtraction; a clear sign bit means the divisor fits.
    assign w_trial     = w_rem_shift - {1'b0, r_divisor};
    assign w_q_bit     = ~w_trial[bw];
    // Restore on a negative trial. The kept value is < divisor, so bw bits suffice.
    assign w_rem_next  = w_q_bit ? w_trial[bw-1:0] : w_rem_shift[bw-1:0];
    assign w_quot_next = {r_dividend[bw-2:0], w_q_bit};

    // ------------------------------------------------------------------
    // Result sign fix-up, applied only when Q/R are written
    // ------------------------------------------------------------------
    logic [bw-1:0]   w_q_final;
    logic [bw-1:0]   w_r_final;

`ifdef SIGNED_DIV_EN
    // The -2^(bw-1) / -1 overflow lands on 0x8000 naturally: magnitude 2^(bw-1), no negation.
    assign w_q_final = r_neg_q ? -w_quot_next : w_quot_next;
    assign w_r_final = r_neg_r ? -w_rem_next  : w_rem_next;
`else
    assign w_q_final = w_quot_next;
    assign w_r_final = w_rem_next;
`endif

    // ------------------------------------------------------------------
    // Control FSM and datapath: accept, iterate, publish result
    // ------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them see the pre-edge
    // values of each other; a blocking = would let r_dividend's new value
    // leak into w_q_bit within the same edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= S_IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_zero     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dz       <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                // IDLE and DONE both accept a new request; DONE with start
                // goes straight back to RUN so back-to-back ops have no bubble.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dividend <= w_a_load;
                        r_divisor  <= w_b_load;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_zero     <= w_b_zero;
                        r_busy     <= 1'b1;
`ifdef SIGNED_DIV_EN
                        r_neg_q    <= A[bw] ^ B[bw];
                        r_neg_r    <= A[bw];
`endif
                        r_state    <= S_RUN;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end

                // start is not looked at here: requests while busy are dropped.
                S_RUN: begin
                    if (r_zero) begin
                        r_q     <= '1;
                        r_r     <= r_dividend;
                        r_dz    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_rem      <= w_rem_next;
                        r_dividend <= w_quot_next;
                        r_cnt      <= r_cnt + CW'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_q     <= w_q_final;
                            r_r     <= w_r_final;
                            r_dz    <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------
    assign busy        = r_busy;
    assign done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_divider_seq.sv
// ----------------------------------------------------------------------------
// tb_divider_seq
//   Scoreboard bench for divider_seq (bw = 16). The driver pushes the
//   hand-computed result and the cycle on which done must appear; a separate
//   monitor on the falling edge pops and compares whenever done is high, and
//   otherwise checks busy and that Q/R/div_by_zero hold the last result.
//   Build with +define+SIGNED_DIV_EN to exercise the signed configuration.
// ----------------------------------------------------------------------------
module tb_divider_seq;

    localparam int BW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [BW:1]   a_in;
    logic [BW:1]   b_in;
    logic          busy;
    logic          done;
    logic [BW:1]   q_out;
    logic [BW:1]   r_out;
    logic          dz_out;

    divider_seq #(.bw(BW)) dut (
        .CLK         (clk),
        .RESETn      (rst_n),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .Q           (q_out),
        .R           (r_out),
        .div_by_zero (dz_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: value seen at a falling edge = rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          acc_cyc;   // first falling edge with busy expected
        int          exp_cyc;   // falling edge on which done must be seen
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] h_q   = '0;
    logic [15:0] h_r   = '0;
    logic        h_dz  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1, required no pending op (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("Q",           32'(q_out),  32'(e.q));
                    check("R",           32'(r_out),  32'(e.r));
                    check("div_by_zero", 32'(dz_out), 32'(e.dz));
                    check("done_cycle",  32'(cyc),    32'(e.exp_cyc));
                    check("busy_at_done", 32'(busy),  32'(0));
                    h_q  = e.q;
                    h_r  = e.r;
                    h_dz = e.dz;
                end
            end else begin
                exp_busy = (sb.size() != 0) && (cyc >= sb[0].acc_cyc) && (cyc < sb[0].exp_cyc);
                check("busy",        32'(busy),   32'(exp_busy));
                check("hold_Q",      32'(q_out),  32'(h_q));
                check("hold_R",      32'(r_out),  32'(h_r));
                check("hold_dz",     32'(dz_out), 32'(h_dz));
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input logic [15:0] b, input logic [15:0] q,
                            input logic [15:0] r, input logic dz);
        exp_t e;
        e.q       = q;
        e.r       = r;
        e.dz      = dz;
        e.acc_cyc = cyc + 1;
        e.exp_cyc = cyc + 1 + ((b == 16'h0) ? 1 : BW);
        sb.push_back(e);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r, input logic dz);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        push_exp(b, q, r, dz);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: got %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input vec_t v);
        issue(v.a, v.b, v.q, v.r, v.dz);
        wait_idle();
    endtask

`ifdef SIGNED_DIV_EN
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 16'h0) begin
            v.q  = 16'hFFFF;
            v.r  = a;
            v.dz = 1'b1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            v.q  = 16'h8000;
            v.r  = 16'h0000;
            v.dz = 1'b0;
        end else begin
            v.q  = 16'($signed(a) / $signed(b));
            v.r  = 16'($signed(a) % $signed(b));
            v.dz = 1'b0;
        end
        return v;
    endfunction

    vec_t tbl [0:7] = '{
        '{a:16'h0064, b:16'h0007, q:16'h000E, r:16'h0002, dz:1'b0},
        '{a:16'hFFF9, b:16'h0002, q:16'hFFFD, r:16'hFFFF, dz:1'b0},
        '{a:16'h8000, b:16'hFFFF, q:16'h8000, r:16'h0000, dz:1'b0},
        '{a:16'h0007, b:16'hFFFE, q:16'hFFFD, r:16'h0001, dz:1'b0},
        '{a:16'hFFF9, b:16'hFFFE, q:16'h0003, r:16'hFFFF, dz:1'b0},
        '{a:16'hFFF9, b:16'h0000, q:16'hFFFF, r:16'hFFF9, dz:1'b1},
        '{a:16'h0009, b:16'h0003, q:16'h0003, r:16'h0000, dz:1'b0},
        '{a:16'h8000, b:16'h0001, q:16'h8000, r:16'h0000, dz:1'b0}
    };
`else
    vec_t tbl [0:9] = '{
        '{a:16'h0064, b:16'h0007, q:16'h000E, r:16'h0002, dz:1'b0},
        '{a:16'hFFFF, b:16'h0001, q:16'hFFFF, r:16'h0000, dz:1'b0},
        '{a:16'h0005, b:16'hFFFF, q:16'h0000, r:16'h0005, dz:1'b0},
        '{a:16'h04D2, b:16'h0000, q:16'hFFFF, r:16'h04D2, dz:1'b1},
        '{a:16'h0009, b:16'h0003, q:16'h0003, r:16'h0000, dz:1'b0},
        '{a:16'hFFFF, b:16'hFFFF, q:16'h0001, r:16'h0000, dz:1'b0},
        '{a:16'h8000, b:16'h0003, q:16'h2AAA, r:16'h0002, dz:1'b0},
        '{a:16'h0000, b:16'h0005, q:16'h0000, r:16'h0000, dz:1'b0},
        '{a:16'h03E8, b:16'h000A, q:16'h0064, r:16'h0000, dz:1'b0},
        '{a:16'hFFFF, b:16'h0100, q:16'h00FF, r:16'h00FF, dz:1'b0}
    };
`endif

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_Q",    32'(q_out),  32'(0));
        check("rst_R",    32'(r_out),  32'(0));
        check("rst_done", 32'(done),   32'(0));
        check("rst_busy", 32'(busy),   32'(0));
        check("rst_dz",   32'(dz_out), 32'(0));
        rst_n = 1'b1;

        // Directed table
        foreach (tbl[i]) run(tbl[i]);

        // Start while busy is ignored; start held in DONE is accepted back-to-back.
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a_in  = 16'd50;
        b_in  = 16'd5;
        @(negedge clk);
        start = 1'b0;
        a_in  = 16'd100;
        b_in  = 16'd7;
        seen  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL b2b_wait: got no done, required done within 60 cycles");
            sb.delete();
        end else begin
            start = 1'b1;
            a_in  = 16'd50;
            b_in  = 16'd5;
            push_exp(16'd5, 16'd10, 16'd0, 1'b0);
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle();

        // Reset in the middle of RUN aborts without a done pulse.
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        h_q  = '0;
        h_r  = '0;
        h_dz = 1'b0;
        #1;
        check("abort_Q",    32'(q_out),  32'(0));
        check("abort_R",    32'(r_out),  32'(0));
        check("abort_busy", 32'(busy),   32'(0));
        check("abort_done", 32'(done),   32'(0));
        check("abort_dz",   32'(dz_out), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("abort_no_done", 32'(done), 32'(0));
        rst_n = 1'b1;
        issue(16'd9, 16'd2, 16'd4, 16'd1, 1'b0);
        wait_idle();

`ifdef SIGNED_DIV_EN
        // Signed sweep against the $signed reference model.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 50 == 0) rb = 16'h0;
            if (i % 97 == 0) begin
                ra = 16'h8000;
                rb = 16'hFFFF;
            end
            run(model(ra, rb));
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
